// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that time-shares one asynchronous-read RAM port between writes and reads.
// A hold register buffers pushes and an output register presents the head word.
module ram_fifo_ctrl #(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned ADDRWIDTH = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DATAWIDTH-1:0] push_data_i,
   output logic                 push_ready_o,
   input  logic                 pop_i,
   output logic [DATAWIDTH-1:0] pop_data_o,
   output logic                 pop_valid_o,
   output logic [ADDRWIDTH+1:0] count_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [ADDRWIDTH-1:0] ram_addr_o,
   output logic [DATAWIDTH-1:0] ram_data_o,
   output logic                 ram_wen_o,
   input  logic [DATAWIDTH-1:0] ram_data_i
);

   localparam int unsigned DEPTH = 1 << ADDRWIDTH;
   localparam logic [ADDRWIDTH:0] DepthW = (ADDRWIDTH+1)'(DEPTH);
   localparam logic [ADDRWIDTH+1:0] FullCount = (ADDRWIDTH+2)'(DEPTH + 2);

   typedef enum logic [2:0] {
      StIdle  = 3'b001,
      StWrite = 3'b010,
      StRead  = 3'b100
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDRWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDRWIDTH:0]     mem_count_q, mem_count_d;
   logic [DATAWIDTH-1:0]   hold_q, hold_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [DATAWIDTH-1:0]   out_q, out_d;
   logic                   pop_valid_q, pop_valid_d;
   logic                   wen_q, wen_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic                   push_acc, pop_acc;

   assign push_ready_o = !hold_valid_q || (state_q == StWrite);
   assign push_acc     = push_i && push_ready_o;
   assign pop_acc      = pop_i && pop_valid_q;

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      out_d        = out_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_count_d  = mem_count_q;
      state_d      = StIdle;

      // A push in a WRITE cycle reloads the hold register as the old word leaves.
      if (push_acc) begin
         hold_d       = push_data_i;
         hold_valid_d = 1'b1;
      end else if (state_q == StWrite) begin
         hold_valid_d = 1'b0;
      end

      unique case (state_q)
         StWrite: begin
            wr_ptr_d    = wr_ptr_q + ADDRWIDTH'(1);
            mem_count_d = mem_count_q + (ADDRWIDTH+1)'(1);
         end
         StRead: begin
            out_d       = ram_data_i;
            rd_ptr_d    = rd_ptr_q + ADDRWIDTH'(1);
            mem_count_d = mem_count_q - (ADDRWIDTH+1)'(1);
         end
         default: ;
      endcase

      pop_valid_d = (pop_valid_q && !pop_acc) || (state_q == StRead);

      // Refilling the output register wins; it cannot repeat, so writes never starve.
      if (!pop_valid_d && (mem_count_d != '0)) begin
         state_d = StRead;
      end else if (hold_valid_d && (mem_count_d < DepthW)) begin
         state_d = StWrite;
      end else begin
         state_d = StIdle;
      end

      wen_d  = (state_d == StWrite);
      addr_d = (state_d == StWrite) ? wr_ptr_d : rd_ptr_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_count_q  <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         out_q        <= '0;
         pop_valid_q  <= 1'b0;
         wen_q        <= 1'b0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_count_q  <= mem_count_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         out_q        <= out_d;
         pop_valid_q  <= pop_valid_d;
         wen_q        <= wen_d;
         addr_q       <= addr_d;
      end
   end

   assign ram_wen_o   = wen_q;
   assign ram_addr_o  = addr_q;
   assign ram_data_o  = hold_q;
   assign pop_data_o  = out_q;
   assign pop_valid_o = pop_valid_q;
   assign count_o     = (ADDRWIDTH+2)'(mem_count_q) + (ADDRWIDTH+2)'(hold_valid_q)
                      + (ADDRWIDTH+2)'(pop_valid_q);
   assign full_o      = (count_o == FullCount);
   assign empty_o     = (count_o == '0);

endmodule
